// File: rtl/word_aligner.sv
// Fabric word aligner: finds the bit offset of a training pattern in a 2*WIDTH window of
// consecutive deserializer words, verifies it, locks, and monitors training errors.
module word_aligner #(
    parameter int unsigned      WIDTH                = 10,
    parameter logic [WIDTH-1:0] TRAINING_PATTERN     = 10'b1111100000,
    parameter int unsigned      MATCHES_REQUIRED     = 16,
    parameter int unsigned      MISMATCHES_TO_UNLOCK = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           input_word,
    input  logic                       training,
    input  logic                       realign,
    output logic [WIDTH-1:0]           output_word,
    output logic                       locked,
    output logic [$clog2(WIDTH)-1:0]   offset,
    output logic [15:0]                error_count
);

    localparam int unsigned OW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] previous_word;
    logic [7:0]       match_count;
    logic [7:0]       match_count_next;
    logic [7:0]       miss_count;
    logic [7:0]       miss_count_next;
    logic [OW-1:0]    offset_next;
    logic [OW-1:0]    offset_inc;
    logic             error_inc;

    logic [2*WIDTH-1:0] window;
    logic [OW:0]        select;
    logic [WIDTH-1:0]   candidate;
    logic               match;

    // Bit 0 of the window is the oldest received bit.
    assign window     = {input_word, previous_word};
    assign select     = {1'b0, offset};
    assign candidate  = window[select +: WIDTH];
    assign match      = (candidate == TRAINING_PATTERN);
    assign offset_inc = (offset == OW'(WIDTH - 1)) ? '0 : offset + OW'(1);

    always_comb begin
        state_next       = state;
        offset_next      = offset;
        match_count_next = match_count;
        miss_count_next  = miss_count;
        error_inc        = 1'b0;

        case (state)
            SEARCH: begin
                if (match) begin
                    state_next       = VERIFY;
                    match_count_next = 8'd1;
                end else begin
                    offset_next = offset_inc;
                end
            end
            VERIFY: begin
                if (match) begin
                    if (match_count == 8'(MATCHES_REQUIRED - 1)) begin
                        state_next      = LOCKED;
                        miss_count_next = '0;
                    end else begin
                        match_count_next = match_count + 8'd1;
                    end
                end else begin
                    state_next       = SEARCH;
                    offset_next      = offset_inc;
                    match_count_next = '0;
                end
            end
            LOCKED: begin
                if (training) begin
                    if (match) begin
                        miss_count_next = '0;
                    end else begin
                        error_inc = 1'b1;
                        if (miss_count == 8'(MISMATCHES_TO_UNLOCK - 1)) begin
                            state_next       = SEARCH;
                            miss_count_next  = '0;
                            match_count_next = '0;
                            offset_next      = offset_inc;
                        end else begin
                            miss_count_next = miss_count + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase

        // Realign overrides any transition but still lets a LOCKED-state error be counted.
        if (realign) begin
            state_next       = SEARCH;
            offset_next      = offset;
            match_count_next = '0;
            miss_count_next  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= SEARCH;
            previous_word <= '0;
            output_word   <= '0;
            offset        <= '0;
            match_count   <= '0;
            miss_count    <= '0;
            locked        <= 1'b0;
            error_count   <= '0;
        end else begin
            state         <= state_next;
            previous_word <= input_word;
            output_word   <= candidate;
            offset        <= offset_next;
            match_count   <= match_count_next;
            miss_count    <= miss_count_next;
            locked        <= (state_next == LOCKED);
            if (error_inc && (error_count != '1)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_word_aligner.sv
// Directed bench for word_aligner: table-driven lock and error-burst vectors plus
// hand-written sequences for payload, wrap-around, VERIFY failure, realign and reset.
module tb_word_aligner;

    localparam logic [9:0] P  = 10'b1111100000;
    localparam logic [9:0] R  = 10'h307;   // raw word carrying P at offset 3
    localparam logic [9:0] B  = 10'h306;   // R with bit 0 flipped: corrupts one candidate
    localparam logic [9:0] R9 = 10'h1F0;   // raw word carrying P at offset 9

    logic        clock;
    logic        reset;
    logic [9:0]  input_word;
    logic        training;
    logic        realign;
    logic [9:0]  output_word;
    logic        locked;
    logic [3:0]  offset;
    logic [15:0] error_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  in_word;
        logic        tr;
        logic        ra;
        logic [9:0]  exp_out;
        logic [3:0]  exp_off;
        logic        exp_locked;
        logic [15:0] exp_err;
    } vec_t;

    vec_t lock_tab[$];
    vec_t burst_tab[$];

    logic [9:0] pay_d [0:100];
    logic [9:0] pay_raw [0:99];

    word_aligner #(
        .WIDTH(10),
        .TRAINING_PATTERN(P),
        .MATCHES_REQUIRED(16),
        .MISMATCHES_TO_UNLOCK(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .input_word(input_word),
        .training(training),
        .realign(realign),
        .output_word(output_word),
        .locked(locked),
        .offset(offset),
        .error_count(error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic [9:0] w, logic tr, logic ra, logic [9:0] o,
                                logic [3:0] off, logic lk, logic [15:0] e);
        vec_t v;
        v.in_word    = w;
        v.tr         = tr;
        v.ra         = ra;
        v.exp_out    = o;
        v.exp_off    = off;
        v.exp_locked = lk;
        v.exp_err    = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        input_word = '0;
        training   = 1'b0;
        realign    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input int idx);
        input_word = v.in_word;
        training   = v.tr;
        realign    = v.ra;
        step();
        chk($sformatf("%s%0d_out", tag, idx), 32'(output_word), 32'(v.exp_out));
        chk($sformatf("%s%0d_off", tag, idx), 32'(offset), 32'(v.exp_off));
        chk($sformatf("%s%0d_lock", tag, idx), 32'(locked), 32'(v.exp_locked));
        chk($sformatf("%s%0d_err", tag, idx), 32'(error_count), 32'(v.exp_err));
    endtask

    initial begin
        // Lock from reset at offset 3: edges 1..3 search, 4 enters VERIFY, 19 locks.
        for (int e = 1; e <= 24; e++) begin
            logic [9:0] o;
            logic [3:0] off;
            o   = (e == 1) ? 10'h000 : (e == 2) ? 10'h383 : (e == 3) ? 10'h3C1 : P;
            off = (e <= 3) ? 4'(e) : 4'd3;
            lock_tab.push_back(mk(R, 1'b1, 1'b0, o, off, (e >= 19), 16'd0));
        end
        // Error bursts while locked: 3 bad, 1 good, 4 bad -> unlock on the last.
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd3, 1'b1, 16'd1));
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd3, 1'b1, 16'd2));
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd3, 1'b1, 16'd3));
        burst_tab.push_back(mk(R, 1'b1, 1'b0, P,       4'd3, 1'b1, 16'd3));
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd3, 1'b1, 16'd4));
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd3, 1'b1, 16'd5));
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd3, 1'b1, 16'd6));
        burst_tab.push_back(mk(B, 1'b1, 1'b0, 10'h360, 4'd4, 1'b0, 16'd7));

        // Payload words and the raw stream that carries them at offset 3.
        for (int n = 0; n <= 100; n++) pay_d[n] = 10'($urandom);
        pay_d[0][6:0] = P[6:0];
        pay_d[100]    = P;
        for (int n = 0; n < 100; n++) pay_raw[n] = {pay_d[n+1][6:0], pay_d[n][9:7]};

        do_reset();
        chk("rst_out", 32'(output_word), 32'd0);
        chk("rst_off", 32'(offset), 32'd0);
        chk("rst_lock", 32'(locked), 32'd0);
        chk("rst_err", 32'(error_count), 32'd0);

        for (int i = 0; i < lock_tab.size(); i++) apply_vec(lock_tab[i], "lock", i);

        training = 1'b0;
        realign  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            input_word = pay_raw[n];
            step();
            chk($sformatf("pay%0d_out", n), 32'(output_word), 32'(pay_d[n]));
            chk($sformatf("pay%0d_lock", n), 32'(locked), 32'd1);
            chk($sformatf("pay%0d_err", n), 32'(error_count), 32'd0);
            chk($sformatf("pay%0d_off", n), 32'(offset), 32'd3);
        end
        input_word = R;
        step();
        chk("pay_end_out", 32'(output_word), 32'(P));
        step();

        for (int i = 0; i < burst_tab.size(); i++) apply_vec(burst_tab[i], "burst", i);

        // Wrap-around: zeros sweep offset to 9, one more failing compare wraps to 0.
        do_reset();
        training = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            input_word = '0;
            step();
            if (k == 9)  chk("wrap_pre_off", 32'(offset), 32'd9);
            if (k == 10) chk("wrap_post_off", 32'(offset), 32'd0);
        end
        for (int k = 11; k <= 35; k++) begin
            input_word = R9;
            step();
            if (k == 11) chk("wrap_first_off", 32'(offset), 32'd1);
            if (k == 19) chk("wrap_sweep_off", 32'(offset), 32'd9);
            if (k == 20) chk("wrap_entry_out", 32'(output_word), 32'(P));
            if (k == 34) chk("wrap_prelock", 32'(locked), 32'd0);
            if (k == 35) begin
                chk("wrap_lock", 32'(locked), 32'd1);
                chk("wrap_lock_off", 32'(offset), 32'd9);
            end
        end

        // Bad word in VERIFY with match_count 8: back to SEARCH, relock after a sweep.
        do_reset();
        training = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            input_word = (k == 12) ? B : R;
            step();
            if (k < 37)  chk($sformatf("vfail%0d_lock", k), 32'(locked), 32'd0);
            if (k == 11) chk("vfail_pre_off", 32'(offset), 32'd3);
            if (k == 12) chk("vfail_bad_off", 32'(offset), 32'd4);
            if (k == 18) chk("vfail_wrap_off", 32'(offset), 32'd0);
            if (k == 21) chk("vfail_sweep_off", 32'(offset), 32'd3);
            if (k == 37) begin
                chk("vfail_relock", 32'(locked), 32'd1);
                chk("vfail_relock_off", 32'(offset), 32'd3);
            end
        end

        // Realign on the same edge as a training mismatch while locked.
        input_word = B;
        realign    = 1'b1;
        step();
        realign = 1'b0;
        chk("realign_lock", 32'(locked), 32'd0);
        chk("realign_err", 32'(error_count), 32'd1);
        chk("realign_off", 32'(offset), 32'd3);
        input_word = R;
        step();
        chk("realign_reacq_off", 32'(offset), 32'd3);
        chk("realign_reacq_lock", 32'(locked), 32'd0);
        repeat (5) step();
        chk("verify_out", 32'(output_word), 32'(P));

        // Asynchronous reset in the middle of VERIFY.
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out", 32'(output_word), 32'd0);
        chk("async_rst_off", 32'(offset), 32'd0);
        chk("async_rst_lock", 32'(locked), 32'd0);
        chk("async_rst_err", 32'(error_count), 32'd0);
        #1 reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/word_aligner.md
# word_aligner

Fabric word aligner placed downstream of a 10-bit (generalised to WIDTH-bit) deserializer whose hardware bitslip is not used. It runs in the word clock domain. It keeps the previous raw word and barrel-shifts the concatenated 2×WIDTH window to find the offset at which a known training pattern appears. It then verifies the pattern for a programmable run of words, declares lock, and holds that offset for payload data, counting training mismatches and dropping lock on sustained errors.

## Interface
- WIDTH, 10, deserialized word width (2..16)
- TRAINING_PATTERN, 10'b1111100000, WIDTH-bit pattern; all WIDTH rotations must be distinct
- MATCHES_REQUIRED, 16, consecutive matches needed to enter LOCKED (2..255)
- MISMATCHES_TO_UNLOCK, 4, consecutive training mismatches in LOCKED that force SEARCH (1..255)
- clock  input  1  word clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- input_word  input  WIDTH  raw deserializer word, one per clock
- training  input  1  high while the transmitter sends TRAINING_PATTERN; gates checking in LOCKED
- realign  input  1  single-cycle request to restart the search
- output_word  output  WIDTH  aligned word, registered
- locked  output  1  high iff state is LOCKED
- offset  output  clog2(WIDTH)  current barrel-shift offset, 0..WIDTH-1
- error_count  output  16  training mismatches seen while LOCKED, saturating

## Operation
- previous_word <= input_word every clock.
- window = {input_word, previous_word}. Bit 0 is the oldest bit. candidate = window[offset +: WIDTH].
- output_word <= candidate every clock, in every state.
- match = (candidate == TRAINING_PATTERN). This is combinational on the current offset.
- States: SEARCH, VERIFY, LOCKED. Counters: match_count (8b), miss_count (8b).
- SEARCH:
  - match: go to VERIFY, match_count <= 1.
  - else: offset <= offset+1, wrapping WIDTH-1 -> 0.
- VERIFY:
  - match and match_count == MATCHES_REQUIRED-1: go to LOCKED, miss_count <= 0.
  - match otherwise: match_count++.
  - mismatch: go to SEARCH, offset advances by 1 with wrap, match_count <= 0.
- LOCKED:
  - offset is frozen.
  - training high and mismatch: error_count++ (saturates at 16'hFFFF), miss_count++.
  - If miss_count reaches MISMATCHES_TO_UNLOCK on that edge: go to SEARCH, miss_count <= 0, offset advances by 1.
  - training high and match: miss_count <= 0.
  - training low: no comparison and no counter change.
- realign high, in any state: next state SEARCH.
  - match_count and miss_count clear; offset is unchanged.
  - realign takes priority over every other transition on the same edge.
  - error_count is not cleared by realign, only by reset.
- VERIFY ignores training; the transmitter must send pattern continuously until locked.

## Timing
- Reset values:
  - output_word = 0, previous_word = 0, offset = 0, locked = 0, error_count = 0.
  - State is SEARCH; both counters are 0.
- Latency from input_word to output_word is 1 clock. Bits taken from previous_word are 2 clocks old.
- locked is registered and rises on the same edge the state enters LOCKED.
- Minimum lock time from reset release with correct offset k:
  - k mismatch edges, then 1 entry edge, then MATCHES_REQUIRED-1 verify edges.
  - The first edge always compares against previous_word = 0, which can only match a pattern whose low bits are 0.
- Wrap-around: offset WIDTH-1 advances to 0. Search continues indefinitely; there is no timeout.
- Reset asserted mid-operation: all outputs return to reset values asynchronously.
- A mismatch in VERIFY on the final required word returns to SEARCH; it does not lock.

## Test plan
- WIDTH=10, pattern 10'b1111100000, stream aligned at offset 3, training=1 from reset release -> offset steps 0,1,2,3. locked rises after edge 19. offset stays 3 and output_word = 10'b1111100000 every cycle thereafter.
- After lock, training=0 with random payload for 100 cycles -> locked stays 1, error_count stays 0, and output_word equals the payload delayed by 1 clock at offset 3.
- After lock, training=1 with 3 corrupted words, then a good word, then 4 corrupted words ->
  - error_count = 7.
  - locked stays 1 through the first burst and falls on the 4th consecutive mismatch edge.
  - offset becomes 4.
- Stream aligned at offset 9, started with offset 9 -> offset wraps 9->0 only if the first compare fails. With the previous_word=0 fill, offset is 0 on the second edge and reaches 9 again on a later sweep before locking.
- In VERIFY with match_count=8, inject 1 bad word -> state returns to SEARCH, offset advances by 1, locked never asserts. Relock occurs after a full sweep.
- realign pulse while LOCKED, on the same edge as a training mismatch -> SEARCH entered, locked=0, error_count increments, offset unchanged. Reset asserted mid-VERIFY -> all outputs are 0 immediately.
